// File: rtl/regfile_pkg.sv
// Shared constants for the scoreboarded register file.
// Defaults for the data/address widths and the reset level of the ready flags.
package regfile_pkg;
  localparam int   N_DEF   = 32;
  localparam int   M_DEF   = 2;
  localparam logic RDY_RST = 1'b1;
endpackage

// File: rtl/regfile_sb_if.sv
// Issue/writeback/read bundle between decode-issue, writeback and the register file.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int M = M_DEF
);
  logic [M-1:0]      r1;
  logic [M-1:0]      r2;
  logic [N-1:0]      v1;
  logic [N-1:0]      v2;
  logic              rdy1;
  logic              rdy2;
  logic              iss_en;
  logic [M-1:0]      iss_rd;
  logic              iss_ok;
  logic              wb_en;
  logic [M-1:0]      wb_rd;
  logic [N-1:0]      wb_data;
  logic [2**M-1:0]   busy;
  logic              err;

  modport master (
    output r1, r2, iss_en, iss_rd, wb_en, wb_rd, wb_data,
    input  v1, v2, rdy1, rdy2, iss_ok, busy, err
  );

  modport slave (
    input  r1, r2, iss_en, iss_rd, wb_en, wb_rd, wb_data,
    output v1, v2, rdy1, rdy2, iss_ok, busy, err
  );
endinterface

// File: rtl/regfile_busy_tracker.sv
// Busy-bit scoreboard: accepts issues, clears on writeback, and exposes the
// post-update vector so read-port ready flags can see this cycle's changes.
module regfile_busy_tracker
  import regfile_pkg::*;
#(
  parameter int M        = M_DEF,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_iss_en,
  input  logic [M-1:0]    i_iss_rd,
  input  logic            i_wb_en,
  input  logic [M-1:0]    i_wb_rd,
  output logic            o_iss_ok,
  output logic [2**M-1:0] o_busy,
  output logic [2**M-1:0] o_busy_nxt
);
  logic [2**M-1:0] r_busy;
  logic [2**M-1:0] w_busy_nxt;

  // Clear before set so an issue landing with its own writeback stays reserved.
  always_comb begin
    o_iss_ok   = i_iss_en && (!r_busy[i_iss_rd] || (i_wb_en && (i_wb_rd == i_iss_rd)));
    w_busy_nxt = r_busy;
    if (i_wb_en)  w_busy_nxt[i_wb_rd]  = 1'b0;
    if (o_iss_ok) w_busy_nxt[i_iss_rd] = 1'b1;
    if (ZERO_REG) w_busy_nxt[0]        = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  assign o_busy     = r_busy;
  assign o_busy_nxt = w_busy_nxt;
endmodule

// File: rtl/regfile_sb.sv
// Register file with two registered write-first read ports, one writeback port
// and a busy-bit scoreboard that reserves destinations between issue and writeback.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int M        = M_DEF,
  parameter bit ZERO_REG = 1'b0
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);
  localparam int NREG = 2**M;

  logic [N-1:0]    r_regs [NREG];
  logic [N-1:0]    r_v1;
  logic [N-1:0]    r_v2;
  logic            r_rdy1;
  logic            r_rdy2;
  logic            r_err;
  logic [NREG-1:0] w_busy;
  logic [NREG-1:0] w_busy_nxt;
  logic            w_wb_we;
  logic            w_z1;
  logic            w_z2;

  regfile_busy_tracker #(
    .M        (M),
    .ZERO_REG (ZERO_REG)
  ) u_busy (
    .clk        (clk),
    .rst        (rst),
    .i_iss_en   (bus.iss_en),
    .i_iss_rd   (bus.iss_rd),
    .i_wb_en    (bus.wb_en),
    .i_wb_rd    (bus.wb_rd),
    .o_iss_ok   (bus.iss_ok),
    .o_busy     (w_busy),
    .o_busy_nxt (w_busy_nxt)
  );

  // A hardwired zero register swallows writebacks entirely, including err.
  assign w_wb_we = bus.wb_en && !(ZERO_REG && (bus.wb_rd == '0));
  assign w_z1    = ZERO_REG && (bus.r1 == '0);
  assign w_z2    = ZERO_REG && (bus.r2 == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_v1   <= '0;
      r_v2   <= '0;
      r_rdy1 <= RDY_RST;
      r_rdy2 <= RDY_RST;
      r_err  <= 1'b0;
    end else begin
      if (w_wb_we) r_regs[bus.wb_rd] <= bus.wb_data;
      r_v1   <= w_z1 ? '0 : ((w_wb_we && (bus.wb_rd == bus.r1)) ? bus.wb_data : r_regs[bus.r1]);
      r_v2   <= w_z2 ? '0 : ((w_wb_we && (bus.wb_rd == bus.r2)) ? bus.wb_data : r_regs[bus.r2]);
      r_rdy1 <= !w_busy_nxt[bus.r1];
      r_rdy2 <= !w_busy_nxt[bus.r2];
      if (w_wb_we && !w_busy[bus.wb_rd]) r_err <= 1'b1;
    end
  end

  assign bus.v1   = r_v1;
  assign bus.v2   = r_v2;
  assign bus.rdy1 = r_rdy1;
  assign bus.rdy2 = r_rdy2;
  assign bus.busy = w_busy;
  assign bus.err  = r_err;
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: directed stimulus queues expected outputs,
// a negedge monitor compares them in the cycle they are due.
module tb_regfile_sb;
   localparam int K_V1 = 0, K_V2 = 1, K_RDY1 = 2, K_RDY2 = 3, K_BUSY = 4, K_ERR = 5, K_ISSOK = 6;

   logic clk = 1'b0;
   logic rst_a;
   logic rst_z;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_mis = 0;

   typedef struct {
      int          due;
      int          dut;
      int          kind;
      logic [31:0] val;
      string       name;
   } exp_t;
   exp_t sbq[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   regfile_sb_if #(.N(32), .M(2)) ifa ();
   regfile_sb_if #(.N(32), .M(2)) ifz ();

   regfile_sb #(.N(32), .M(2), .ZERO_REG(1'b0)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
   regfile_sb #(.N(32), .M(2), .ZERO_REG(1'b1)) dut_z (.clk(clk), .rst(rst_z), .bus(ifz));

   function automatic logic [31:0] sample(int dut, int kind);
      logic [31:0] r;
      r = 'x;
      case (kind)
         K_V1:    r = (dut == 0) ? ifa.v1 : ifz.v1;
         K_V2:    r = (dut == 0) ? ifa.v2 : ifz.v2;
         K_RDY1:  r = {31'd0, (dut == 0) ? ifa.rdy1 : ifz.rdy1};
         K_RDY2:  r = {31'd0, (dut == 0) ? ifa.rdy2 : ifz.rdy2};
         K_BUSY:  r = {28'd0, (dut == 0) ? ifa.busy : ifz.busy};
         K_ERR:   r = {31'd0, (dut == 0) ? ifa.err : ifz.err};
         K_ISSOK: r = {31'd0, (dut == 0) ? ifa.iss_ok : ifz.iss_ok};
         default: r = 'x;
      endcase
      return r;
   endfunction

   task automatic exp_at(int dut, int kind, int due_off, logic [31:0] val, string name);
      exp_t e;
      e.due  = cyc + due_off;
      e.dut  = dut;
      e.kind = kind;
      e.val  = val;
      e.name = name;
      sbq.push_back(e);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_a;
      ifa.r1 = '0; ifa.r2 = '0; ifa.iss_en = 1'b0; ifa.iss_rd = '0;
      ifa.wb_en = 1'b0; ifa.wb_rd = '0; ifa.wb_data = '0;
   endtask

   task automatic idle_z;
      ifz.r1 = '0; ifz.r2 = '0; ifz.iss_en = 1'b0; ifz.iss_rd = '0;
      ifz.wb_en = 1'b0; ifz.wb_rd = '0; ifz.wb_data = '0;
   endtask

   // Monitor: every expectation whose cycle has come is checked and retired.
   always @(negedge clk) begin
      int          i;
      logic [31:0] act;
      i = 0;
      while (i < sbq.size()) begin
         if (sbq[i].due <= cyc) begin
            act = sample(sbq[i].dut, sbq[i].kind);
            n_cmp++;
            if (sbq[i].due != cyc || act !== sbq[i].val) begin
               n_mis++;
               $display("FAIL %s (dut %0d, cycle %0d, due %0d): got %h expected %h",
                        sbq[i].name, sbq[i].dut, cyc, sbq[i].due, act, sbq[i].val);
            end
            sbq.delete(i);
         end else begin
            i++;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_a = 1'b1;
      rst_z = 1'b1;
      idle_a;
      idle_z;
      tick;
      exp_at(0, K_V1, 1, 32'd0, "rst_v1");
      exp_at(0, K_V2, 1, 32'd0, "rst_v2");
      exp_at(0, K_RDY1, 1, 32'd1, "rst_rdy1");
      exp_at(0, K_RDY2, 1, 32'd1, "rst_rdy2");
      exp_at(0, K_BUSY, 1, 32'd0, "rst_busy");
      exp_at(0, K_ERR, 1, 32'd0, "rst_err");
      exp_at(1, K_BUSY, 1, 32'd0, "rst_z_busy");
      tick;

      n_cmp++;
      if (ifa.busy !== 4'h0) begin
         n_mis++;
         $display("FAIL d_rst_busy: got %h expected 0", ifa.busy);
      end
      n_cmp++;
      if (ifa.rdy1 !== 1'b1 || ifa.rdy2 !== 1'b1) begin
         n_mis++;
         $display("FAIL d_rst_rdy: got %b %b expected 1 1", ifa.rdy1, ifa.rdy2);
      end
      n_cmp++;
      if (ifa.err !== 1'b0) begin
         n_mis++;
         $display("FAIL d_rst_err: got %b expected 0", ifa.err);
      end
      n_cmp++;
      if (ifa.v1 !== 32'd0 || ifa.v2 !== 32'd0) begin
         n_mis++;
         $display("FAIL d_rst_v: got %h %h expected 0 0", ifa.v1, ifa.v2);
      end

      rst_a = 1'b0; rst_z = 1'b0;
      ifa.r1 = 2'd0; ifa.r2 = 2'd3;
      exp_at(0, K_BUSY, 0, 32'd0, "t1_busy");
      exp_at(0, K_V1, 1, 32'd0, "t1_v1");
      exp_at(0, K_V2, 1, 32'd0, "t1_v2");
      exp_at(0, K_RDY1, 1, 32'd1, "t1_rdy1");
      exp_at(0, K_RDY2, 1, 32'd1, "t1_rdy2");
      exp_at(0, K_ERR, 1, 32'd0, "t1_err");
      tick;

      ifa.iss_en = 1'b1; ifa.iss_rd = 2'd2; ifa.r1 = 2'd2;
      exp_at(0, K_ISSOK, 0, 32'd1, "t2_iss_ok");
      exp_at(0, K_BUSY, 0, 32'd0, "t2_busy_pre");
      exp_at(0, K_RDY1, 1, 32'd0, "t2_rdy1_pending");
      tick;

      ifa.iss_en = 1'b0; ifa.wb_en = 1'b1; ifa.wb_rd = 2'd2; ifa.wb_data = 32'hDEADBEEF;
      exp_at(0, K_BUSY, 0, 32'h4, "t2_busy_0100");
      exp_at(0, K_V1, 1, 32'hDEADBEEF, "t2_v1_bypass");
      exp_at(0, K_RDY1, 1, 32'd1, "t2_rdy1_after_wb");
      exp_at(0, K_BUSY, 1, 32'd0, "t2_busy_cleared");
      exp_at(0, K_ERR, 1, 32'd0, "t2_err");
      tick;

      ifa.wb_en = 1'b0;
      exp_at(0, K_V1, 1, 32'hDEADBEEF, "t2_v1_array");
      tick;

      ifa.iss_en = 1'b1; ifa.iss_rd = 2'd1; ifa.r1 = 2'd1;
      exp_at(0, K_ISSOK, 0, 32'd1, "t3_iss1_ok");
      tick;

      exp_at(0, K_ISSOK, 0, 32'd0, "t3_waw_refused");
      exp_at(0, K_BUSY, 0, 32'h2, "t3_busy_0010");
      tick;

      ifa.wb_en = 1'b1; ifa.wb_rd = 2'd1; ifa.wb_data = 32'h11112222;
      exp_at(0, K_ISSOK, 0, 32'd1, "t3_iss_with_wb_ok");
      exp_at(0, K_BUSY, 1, 32'h2, "t3_set_wins");
      exp_at(0, K_RDY1, 1, 32'd0, "t3_rdy1_still_busy");
      exp_at(0, K_V1, 1, 32'h11112222, "t3_v1_bypass");
      tick;

      ifa.iss_en = 1'b0; ifa.wb_en = 1'b0; ifa.r2 = 2'd1;
      exp_at(0, K_V2, 1, 32'h11112222, "t3_v2_array");
      exp_at(0, K_BUSY, 0, 32'h2, "t3_busy_held");
      tick;

      ifa.wb_en = 1'b1; ifa.wb_rd = 2'd1; ifa.wb_data = 32'h33;
      exp_at(0, K_ERR, 1, 32'd0, "t3_err_clean_wb");
      exp_at(0, K_BUSY, 1, 32'd0, "t3_busy_cleared");
      tick;

      ifa.wb_rd = 2'd3; ifa.wb_data = 32'd5; ifa.r2 = 2'd3;
      exp_at(0, K_V2, 1, 32'd5, "t4_v2_bypass");
      exp_at(0, K_ERR, 1, 32'd1, "t4_err_set");
      tick;

      ifa.wb_en = 1'b0; ifa.r1 = 2'd3; ifa.r2 = 2'd3;
      exp_at(0, K_V1, 1, 32'd5, "t4_v1_same_reg");
      exp_at(0, K_V2, 1, 32'd5, "t4_v2_same_reg");
      exp_at(0, K_ERR, 1, 32'd1, "t4_err_sticky");
      tick;

      n_cmp++;
      if (ifa.err !== 1'b1) begin
         n_mis++;
         $display("FAIL d_err_sticky: got %b expected 1", ifa.err);
      end
      n_cmp++;
      if (ifa.v1 !== 32'd5 || ifa.v2 !== 32'd5) begin
         n_mis++;
         $display("FAIL d_same_reg: got %h %h expected 5 5", ifa.v1, ifa.v2);
      end

      ifa.iss_en = 1'b1; ifa.iss_rd = 2'd1;
      exp_at(0, K_ISSOK, 0, 32'd1, "t6_iss1_ok");
      tick;

      ifa.iss_rd = 2'd3;
      exp_at(0, K_ISSOK, 0, 32'd1, "t6_iss3_ok");
      tick;

      ifa.iss_en = 1'b0; rst_a = 1'b1;
      ifa.wb_en = 1'b1; ifa.wb_rd = 2'd1; ifa.wb_data = 32'hABCD; ifa.r1 = 2'd1; ifa.r2 = 2'd3;
      n_cmp++;
      if (ifa.busy !== 4'hA) begin
         n_mis++;
         $display("FAIL d_busy_1010: got %h expected a", ifa.busy);
      end
      exp_at(0, K_BUSY, 0, 32'hA, "t6_busy_1010");
      exp_at(0, K_BUSY, 1, 32'd0, "t6_busy_reset");
      exp_at(0, K_RDY1, 1, 32'd1, "t6_rdy1_reset");
      exp_at(0, K_RDY2, 1, 32'd1, "t6_rdy2_reset");
      exp_at(0, K_V1, 1, 32'd0, "t6_v1_reset");
      exp_at(0, K_V2, 1, 32'd0, "t6_v2_reset");
      exp_at(0, K_ERR, 1, 32'd0, "t6_err_reset");
      tick;

      n_cmp++;
      if (ifa.busy !== 4'h0) begin
         n_mis++;
         $display("FAIL d_busy_reset: got %h expected 0", ifa.busy);
      end
      n_cmp++;
      if (ifa.rdy1 !== 1'b1 || ifa.rdy2 !== 1'b1) begin
         n_mis++;
         $display("FAIL d_rdy_reset: got %b %b expected 1 1", ifa.rdy1, ifa.rdy2);
      end

      rst_a = 1'b0; ifa.wb_en = 1'b0; ifa.r1 = 2'd3; ifa.r2 = 2'd1;
      exp_at(0, K_V1, 1, 32'd0, "t6_reg3_cleared");
      exp_at(0, K_V2, 1, 32'd0, "t6_wb_discarded");
      tick;

      ifa.wb_en = 1'b1; ifa.wb_rd = 2'd1; ifa.wb_data = 32'd9;
      exp_at(0, K_ERR, 1, 32'd1, "t6_late_wb_err");
      tick;
      idle_a;

      ifz.wb_en = 1'b1; ifz.wb_rd = 2'd0; ifz.wb_data = 32'd7;
      ifz.iss_en = 1'b1; ifz.iss_rd = 2'd0; ifz.r1 = 2'd0;
      exp_at(1, K_ISSOK, 0, 32'd1, "t5_iss0_ok");
      exp_at(1, K_V1, 1, 32'd0, "t5_v1_zero");
      exp_at(1, K_RDY1, 1, 32'd1, "t5_rdy1_zero");
      exp_at(1, K_BUSY, 1, 32'd0, "t5_busy0_clear");
      exp_at(1, K_ERR, 1, 32'd0, "t5_err_clear");
      tick;

      idle_z;
      ifz.iss_en = 1'b1; ifz.iss_rd = 2'd2; ifz.r1 = 2'd2; ifz.r2 = 2'd0;
      exp_at(1, K_BUSY, 0, 32'd0, "t5_busy_pre");
      exp_at(1, K_RDY1, 1, 32'd0, "t5_rdy1_reg2");
      exp_at(1, K_RDY2, 1, 32'd1, "t5_rdy2_reg0");
      exp_at(1, K_BUSY, 1, 32'h4, "t5_busy_reg2");
      tick;
      idle_z;

      repeat (3) tick;
      for (int k = 0; k < 20 && sbq.size() > 0; k++) tick;
      while (sbq.size() > 0) begin
         n_cmp++;
         n_mis++;
         $display("FAIL %s: never checked, due cycle %0d", sbq[0].name, sbq[0].due);
         void'(sbq.pop_front());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
